wb_stage: RTL

Write-back stage of the multi-cycle CPU, directly upstream of the register file's write port (wreg/waddr/wdata).
- Accepts one retiring instruction per transaction from EX/MEM over a valid/ready handshake.
- For loads, waits for data memory, then performs byte/halfword extraction and sign/zero extension.
- Issues exactly one single-cycle register-file write and a done pulse back to the control FSM.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/load_align.sv | 47 ++++
 rtl/wb_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load-op encodings, write-back FSM states and
// default datapath widths.
package cpu_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    LDOP_LB  = 3'b000,
    LDOP_LBU = 3'b001,
    LDOP_LH  = 3'b010,
    LDOP_LHU = 3'b011,
    LDOP_LW  = 3'b100
  } ldop_e;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_COMMIT   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load-data aligner: picks the byte/halfword/word addressed by
// addr_lo out of a little-endian memory word, extends it and flags misalignment.
module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        ldop,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ext_value,
  output logic              misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    byte_v     = rdata[{addr_lo, 3'b000} +: 8];
    half_v     = rdata[{addr_lo[1], 4'b0000} +: 16];
    ext_value  = rdata;
    misaligned = (addr_lo != 2'b00);
    case (ldop)
      LDOP_LB: begin
        ext_value  = {{(DATA_W-8){byte_v[7]}}, byte_v};
        misaligned = 1'b0;
      end
      LDOP_LBU: begin
        ext_value  = {{(DATA_W-8){1'b0}}, byte_v};
        misaligned = 1'b0;
      end
      LDOP_LH: begin
        ext_value  = {{(DATA_W-16){half_v[15]}}, half_v};
        misaligned = addr_lo[0];
      end
      LDOP_LHU: begin
        ext_value  = {{(DATA_W-16){1'b0}}, half_v};
        misaligned = addr_lo[0];
      end
      // LW and the reserved encodings 101-111 all take the whole word.
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: accepts one retiring instruction, waits for load data if
// needed, then issues a single registered register-file write plus a done pulse.
// Optional retire/exception counters are built when WB_RETIRE_CNT_EN is defined.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_wen,
  input  logic [RADDR_W-1:0] in_waddr,
  input  logic               in_is_load,
  input  logic [2:0]         in_ldop,
  input  logic [1:0]         in_addr_lo,
  input  logic [DATA_W-1:0]  in_result,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               wreg,
  output logic [RADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]  wdata,
  output logic               done,
  output logic               exc_adel
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]        retire_cnt,
  output logic [15:0]        exc_cnt
`endif
);

  wb_state_e            state_q, state_d;
  logic                 wen_q, wen_d;
  logic [RADDR_W-1:0]   dst_q, dst_d;
  logic [2:0]           ldop_q, ldop_d;
  logic [1:0]           addr_lo_q, addr_lo_d;
  logic                 wreg_q, wreg_d;
  logic [RADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 exc_q, exc_d;

  logic [DATA_W-1:0]    ld_value;
  logic                 ld_misaligned;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .ldop       (ldop_q),
    .addr_lo    (addr_lo_q),
    .rdata      (mem_rdata),
    .ext_value  (ld_value),
    .misaligned (ld_misaligned)
  );

  assign in_ready = (state_q == WB_IDLE) && resetn;

  // Commit outputs are computed on the edge entering COMMIT so they are
  // registered and valid for exactly the one COMMIT cycle.
  always_comb begin
    state_d   = state_q;
    wen_d     = wen_q;
    dst_d     = dst_q;
    ldop_d    = ldop_q;
    addr_lo_d = addr_lo_q;
    wreg_d    = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    exc_d     = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (in_valid && in_ready) begin
          wen_d     = in_wen;
          dst_d     = in_waddr;
          ldop_d    = in_ldop;
          addr_lo_d = in_addr_lo;
          if (in_is_load) begin
            state_d = WB_WAIT_MEM;
          end else begin
            state_d = WB_COMMIT;
            wreg_d  = in_wen && (in_waddr != '0);
            waddr_d = in_waddr;
            wdata_d = in_result;
            done_d  = 1'b1;
          end
        end
      end
      WB_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = WB_COMMIT;
          wreg_d  = wen_q && (dst_q != '0) && !ld_misaligned;
          waddr_d = dst_q;
          wdata_d = ld_value;
          exc_d   = ld_misaligned;
          done_d  = 1'b1;
        end
      end
      WB_COMMIT: state_d = WB_IDLE;
      default:   state_d = WB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= WB_IDLE;
      wen_q     <= 1'b0;
      dst_q     <= '0;
      ldop_q    <= '0;
      addr_lo_q <= '0;
      wreg_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      dst_q     <= dst_d;
      ldop_q    <= ldop_d;
      addr_lo_q <= addr_lo_d;
      wreg_q    <= wreg_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      exc_q     <= exc_d;
    end
  end

  assign wreg     = wreg_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign done     = done_q;
  assign exc_adel = exc_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;
  logic [15:0] exc_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retire_cnt_q <= '0;
      exc_cnt_q    <= '0;
    end else begin
      if (done_q) retire_cnt_q <= retire_cnt_q + 32'd1;
      if (exc_q && (exc_cnt_q != 16'hFFFF)) exc_cnt_q <= exc_cnt_q + 16'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign exc_cnt    = exc_cnt_q;
`else
  // Counter-free build: no extra ports or state.
`endif

endmodule
